arb_requester: RTL and testbench

//  Requester-side client of the 3-way request/grant arbiter; one instance per request line.

---
 rtl/arb_requester.sv | 80 ++++++++
 tb/tb_arb_requester.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_requester.sv
// arb_requester: requester-side client of a request/grant arbiter; queues jobs, requests, streams beats while granted.
module arb_requester #(
    parameter int LEN_W      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             job_valid_i,
    input  logic [LEN_W-1:0] job_len_i,
    output logic             job_ready_o,
    output logic             req_o,
    input  logic             gnt_i,
    output logic             beat_valid_o,
    output logic             beat_last_o,
    output logic             busy_o,
    output logic             timeout_err_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, REQ, XFER, REL} state_e;
    state_e           state_q;
    logic [LEN_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      fill_q, fill_d;
    logic [LEN_W-1:0] cnt_q;
    logic [WW-1:0]    wait_q;
    logic             retry_q;
    logic             push, pop, empty;
    assign empty         = fill_q == '0;
    assign job_ready_o   = fill_q != (AW+1)'(FIFO_DEPTH);
    assign push          = job_valid_i & job_ready_o;
    assign pop           = (state_q == IDLE) & !empty;
    assign fill_d        = fill_q + (AW+1)'(push) - (AW+1)'(pop);
    assign req_o         = (state_q == REQ) | (state_q == XFER);
    assign beat_valid_o  = (state_q == XFER) & gnt_i;
    assign beat_last_o   = beat_valid_o & (cnt_q == '0);
    assign busy_o        = (state_q != IDLE) | !empty;
    assign timeout_err_o = (state_q == REQ) & !gnt_i & (wait_q == WW'(TIMEOUT - 1));
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q] <= job_len_i;
    end
    // cnt holds beats-1 of the active job and survives a timeout so the retry reissues it
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            wait_q  <= '0;
            retry_q <= 1'b0;
        end else begin
            fill_q <= fill_d;
            if (push) wr_q <= wr_q + AW'(1);
            if (pop) rd_q <= rd_q + AW'(1);
            case (state_q)
                IDLE: if (!empty) begin
                    state_q <= REQ;
                    cnt_q   <= mem_q[rd_q];
                    wait_q  <= '0;
                end
                REQ: if (gnt_i) state_q <= XFER;
                    else if (timeout_err_o) begin
                        state_q <= REL;
                        retry_q <= 1'b1;
                    end else wait_q <= wait_q + WW'(1);
                XFER: if (gnt_i) begin
                    if (cnt_q == '0) state_q <= REL;
                    else cnt_q <= cnt_q - LEN_W'(1);
                end
                REL: begin
                    state_q <= retry_q ? REQ : IDLE;
                    wait_q  <= '0;
                    retry_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_arb_requester.sv
// tb_arb_requester: directed scenarios plus a randomized run against a job-level reference model.
module tb_arb_requester;
    localparam int TO = 15;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       jv = 1'b0;
    logic [3:0] jl = '0;
    logic       g = 1'b0;
    logic       ready, req, bv, bl, busy, to;
    int         tests = 0;
    int         fails = 0;
    arb_requester #(.LEN_W(4), .FIFO_DEPTH(4), .TIMEOUT(TO)) dut (
        .clk_i(clk), .reset_i(reset), .job_valid_i(jv), .job_len_i(jl), .job_ready_o(ready),
        .req_o(req), .gnt_i(g), .beat_valid_o(bv), .beat_last_o(bl), .busy_o(busy),
        .timeout_err_o(to)
    );
    always #5 clk = ~clk;
    task automatic adv();
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        reset = 1'b1; jv = 1'b0; g = 1'b0;
        adv(); adv();
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if ({req, bv, bl, to, busy, ready} !== 6'b000001) begin
            fails++; $display("FAIL reset {req,bv,bl,to,busy,ready} got %b want 000001", {req, bv, bl, to, busy, ready});
        end
        adv();
    endtask
    task automatic test_single();
        jv = 1'b1; jl = 4'd3; g = 1'b0;
        adv();
        jv = 1'b0;
        @(negedge clk);
        tests++;
        if ({req, busy} !== 2'b01) begin fails++; $display("FAIL single_e0 {req,busy} got %b want 01", {req, busy}); end
        adv();
        g = 1'b1;
        @(negedge clk);
        tests++;
        if ({req, bv} !== 2'b10) begin fails++; $display("FAIL single_e1 {req,bv} got %b want 10", {req, bv}); end
        adv();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if ({req, bv, bl} !== {2'b11, i == 3}) begin
                fails++; $display("FAIL single_beat%0d {req,bv,bl} got %b want %b", i, {req, bv, bl}, {2'b11, i == 3});
            end
            adv();
        end
        @(negedge clk);
        tests++;
        if ({req, bv, busy} !== 3'b001) begin fails++; $display("FAIL single_rel {req,bv,busy} got %b want 001", {req, bv, busy}); end
        adv();
        @(negedge clk);
        tests++;
        if ({req, busy} !== 2'b00) begin fails++; $display("FAIL single_idle {req,busy} got %b want 00", {req, busy}); end
        g = 1'b0;
        adv();
    endtask
    task automatic test_toggle();
        logic [4:0] pat = 5'b10101;
        int nb = 0;
        jv = 1'b1; jl = 4'd2; g = 1'b0;
        adv();
        jv = 1'b0;
        adv();
        g = 1'b1;
        adv();
        for (int i = 0; i < 5; i++) begin
            g = pat[i];
            @(negedge clk);
            tests++;
            if ({req, bv, bl} !== {1'b1, g, g && nb == 2}) begin
                fails++; $display("FAIL toggle%0d {req,bv,bl} got %b want %b", i, {req, bv, bl}, {1'b1, g, g && nb == 2});
            end
            if (g) nb++;
            adv();
        end
        @(negedge clk);
        tests++;
        if ({req, bv} !== 2'b00) begin fails++; $display("FAIL toggle_rel {req,bv} got %b want 00", {req, bv}); end
        g = 1'b0;
        adv();
    endtask
    task automatic test_timeout();
        jv = 1'b1; jl = 4'd1; g = 1'b0;
        adv();
        jv = 1'b0;
        adv();
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            tests++;
            if ({req, to} !== {1'b1, i == TO - 1}) begin
                fails++; $display("FAIL timeout_wait%0d {req,to} got %b want %b", i, {req, to}, {1'b1, i == TO - 1});
            end
            adv();
        end
        @(negedge clk);
        tests++;
        if ({req, to} !== 2'b00) begin fails++; $display("FAIL timeout_rel {req,to} got %b want 00", {req, to}); end
        adv();
        g = 1'b1;
        @(negedge clk);
        tests++;
        if ({req, to, bv} !== 3'b100) begin fails++; $display("FAIL timeout_retry {req,to,bv} got %b want 100", {req, to, bv}); end
        adv();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests++;
            if ({bv, bl} !== {1'b1, i == 1}) begin
                fails++; $display("FAIL timeout_beat%0d {bv,bl} got %b want %b", i, {bv, bl}, {1'b1, i == 1});
            end
            adv();
        end
        @(negedge clk);
        tests++;
        if (req !== 1'b0) begin fails++; $display("FAIL timeout_done req got %b want 0", req); end
        g = 1'b0;
        adv();
    endtask
    task automatic test_fifo_full();
        int exp_q[$];
        int nb = 0;
        int low = 0;
        int cyc = 0;
        g = 1'b0;
        for (int k = 0; k < 6; k++) begin
            jv = 1'b1; jl = 4'($urandom_range(0, 3));
            @(negedge clk);
            tests++;
            if (ready !== (k < 5)) begin fails++; $display("FAIL fifo_ready%0d got %b want %b", k, ready, k < 5); end
            if (k < 5) exp_q.push_back(int'(jl));
            adv();
        end
        jv = 1'b0; g = 1'b1;
        while (exp_q.size() > 0 && cyc < 300) begin
            @(negedge clk);
            if (req === 1'b0) low++;
            else begin
                if (low != 0) begin
                    tests++;
                    if (low != 2) begin fails++; $display("FAIL fifo_gap req low %0d cycles want 2", low); end
                end
                low = 0;
            end
            if (bv === 1'b1) nb++;
            if (bl === 1'b1) begin
                tests++;
                if (nb != exp_q[0] + 1) begin fails++; $display("FAIL fifo_job beats got %0d want %0d", nb, exp_q[0] + 1); end
                void'(exp_q.pop_front());
                nb = 0;
            end
            adv();
            cyc++;
        end
        tests++;
        if (exp_q.size() != 0) begin fails++; $display("FAIL fifo_drain jobs left %0d want 0", exp_q.size()); end
        adv();
        @(negedge clk);
        tests++;
        if ({req, busy} !== 2'b00) begin fails++; $display("FAIL fifo_idle {req,busy} got %b want 00", {req, busy}); end
        g = 1'b0;
        adv();
    endtask
    task automatic test_reset_mid();
        jv = 1'b1; jl = 4'd3; g = 1'b0;
        adv();
        jl = 4'd2;
        adv();
        jv = 1'b0; g = 1'b1;
        adv();
        adv();
        adv();
        @(negedge clk);
        tests++;
        if ({bv, bl} !== 2'b10) begin fails++; $display("FAIL rstmid_pre {bv,bl} got %b want 10", {bv, bl}); end
        reset = 1'b1;
        adv();
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if ({req, bv, busy, ready} !== 4'b0001) begin
            fails++; $display("FAIL rstmid_post {req,bv,busy,ready} got %b want 0001", {req, bv, busy, ready});
        end
        for (int i = 0; i < 6; i++) begin
            adv();
            @(negedge clk);
            tests++;
            if ({req, bv} !== 2'b00) begin fails++; $display("FAIL rstmid_stale%0d {req,bv} got %b want 00", i, {req, bv}); end
        end
        g = 1'b0;
        adv();
    endtask
    task automatic test_spurious();
        g = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if ({req, bv, busy} !== 3'b000) begin fails++; $display("FAIL spurious%0d {req,bv,busy} got %b want 000", i, {req, bv, busy}); end
            adv();
        end
        g = 1'b0;
    endtask
    // Model tracks pending lengths and the remaining beats of the job in hand
    task automatic test_random();
        int q[$];
        int job = 0;
        int waited = 0;
        bit granted = 0;
        bit rel = 0;
        bit lowg = 0;
        bit rdy;
        logic [5:0] exp_v;
        reset = 1'b1; jv = 1'b0; g = 1'b0;
        adv();
        reset = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (c % 50 == 0) lowg = 1'($urandom_range(0, 1));
            jv = ($urandom_range(0, 2) == 0);
            jl = ($urandom_range(0, 9) == 0) ? 4'hf : 4'($urandom_range(0, 3));
            g = lowg ? ($urandom_range(0, 19) == 0) : 1'($urandom_range(0, 1));
            rdy = q.size() < 4;
            exp_v = {job > 0 && !rel, granted && g, granted && g && job == 1,
                     job > 0 && !granted && !rel && !g && waited == TO - 1,
                     job > 0 || rel || q.size() > 0, rdy};
            @(negedge clk);
            tests++;
            if ({req, bv, bl, to, busy, ready} !== exp_v) begin
                fails++; $display("FAIL random_c%0d {req,bv,bl,to,busy,ready} got %b want %b", c, {req, bv, bl, to, busy, ready}, exp_v);
            end
            if (rel) begin
                rel = 0; waited = 0;
            end else if (job == 0) begin
                if (q.size() > 0) begin job = q.pop_front() + 1; waited = 0; end
            end else if (!granted) begin
                if (g) granted = 1;
                else if (waited == TO - 1) rel = 1;
                else waited++;
            end else if (g) begin
                job--;
                if (job == 0) begin granted = 0; rel = 1; end
            end
            if (jv && rdy) q.push_back(int'(jl));
            adv();
        end
        jv = 1'b0; g = 1'b0;
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        test_reset();
        test_single();
        test_toggle();
        test_timeout();
        test_fifo_full();
        test_reset_mid();
        test_spurious();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
